// File: rtl/param_vending_ctrl_if.sv
// Handshake bundle between the vending controller and its coin front-end,
// dispense actuator and change payout mechanism.
interface param_vending_ctrl_if #(
  parameter int CREDIT_W = 8,
  parameter int STOCK_W  = 4
);
  logic                coin_valid;
  logic                coin_sel;
  logic                cancel;
  logic                restock;
  logic [STOCK_W-1:0]  restock_val;
  logic                chg_ack;
  logic                coin_reject;
  logic                dispense;
  logic                chg_valid;
  logic                chg_sel;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;
  logic                sold_out;

  modport master (
    output coin_valid, coin_sel, cancel,
    output restock, restock_val, chg_ack,
    input  coin_reject, dispense,
    input  chg_valid, chg_sel,
    input  credit, stock, sold_out
  );

  modport slave (
    input  coin_valid, coin_sel, cancel,
    input  restock, restock_val, chg_ack,
    output coin_reject, dispense,
    output chg_valid, chg_sel,
    output credit, stock, sold_out
  );
endinterface

// File: rtl/param_vending_ctrl.sv
// Two-coin vending controller: credit accumulation, vend, coin-by-coin
// change/refund payout over valid/ack, and stock tracking.
module param_vending_ctrl #(
  parameter int CREDIT_W   = 8,
  parameter int PRICE      = 15,
  parameter int COIN0_VAL  = 5,
  parameter int COIN1_VAL  = 10,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input logic clk,
  input logic rst,
  param_vending_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam logic [CREDIT_W-1:0] C0 = CREDIT_W'(COIN0_VAL);
  localparam logic [CREDIT_W-1:0] C1 = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W:0]   P  = (CREDIT_W+1)'(PRICE);
  localparam logic [STOCK_W-1:0]  SI = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0]  S1 = STOCK_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [STOCK_W-1:0]  r_stock;
  logic [STOCK_W-1:0]  w_stock_nxt;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_coin_v;
  logic [CREDIT_W-1:0] w_chg_v;
  logic                w_chg_big;
  logic                w_sold_out;
  logic                w_busy;
  logic                w_accept;

  // Coin/price values the payout logic cannot settle exactly are flagged
  always_ff @(posedge clk) begin
    assert (PRICE % COIN0_VAL == 0 &&
            COIN1_VAL % COIN0_VAL == 0 &&
            COIN1_VAL > COIN0_VAL)
      else $error("param_vending_ctrl: bad coin/price parameters");
  end

  // Shared decode of the current coin, credit sum and change coin
  always_comb begin
    w_sold_out = (r_stock == '0);
    w_busy     = (r_state == S_VEND) || (r_state == S_CHANGE);
    w_coin_v   = bus.coin_sel ? C1 : C0;
    w_accept   = bus.coin_valid & ~w_busy & ~w_sold_out;
    w_sum      = {1'b0, r_credit} + {1'b0, w_coin_v};
    w_chg_big  = (r_credit >= C1);
    w_chg_v    = w_chg_big ? C1 : C0;
  end

  // State and credit register; reset forfeits any held credit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  // Next state and next credit
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    unique case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_accept) begin
          if (w_sum >= P) begin
            w_state_nxt  = S_VEND;
            w_credit_nxt = CREDIT_W'(w_sum - P);
          end else begin
            w_credit_nxt = w_sum[CREDIT_W-1:0];
            w_state_nxt  = bus.cancel ? S_CHANGE : S_COLLECT;
          end
        end else if (r_state == S_COLLECT && bus.cancel) begin
          w_state_nxt = S_CHANGE;
        end
      end
      S_VEND: begin
        w_state_nxt = (r_credit != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        if (bus.chg_ack) begin
          w_credit_nxt = r_credit - w_chg_v;
          if (w_credit_nxt == '0) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stock: restock overrides the vend decrement on the same edge
  always_comb begin
    w_stock_nxt = r_stock;
    if (bus.restock) begin
      w_stock_nxt = bus.restock_val;
    end else if (r_state == S_VEND && !w_sold_out) begin
      w_stock_nxt = r_stock - S1;
    end
  end

  // Stock register, reloaded with the initial count on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stock <= SI;
    end else begin
      r_stock <= w_stock_nxt;
    end
  end

  // Outputs decoded from state; change coin held stable until acked
  always_comb begin
    bus.coin_reject = bus.coin_valid & (w_busy | w_sold_out);
    bus.dispense    = (r_state == S_VEND);
    bus.chg_valid   = (r_state == S_CHANGE);
    bus.chg_sel     = (r_state == S_CHANGE) & w_chg_big;
    bus.credit      = r_credit;
    bus.stock       = r_stock;
    bus.sold_out    = w_sold_out;
  end

endmodule

// File: tb/tb_param_vending_ctrl.sv
// Bench for param_vending_ctrl: directed vector table, hand sequences
// for restock/sold-out/async reset, then random traffic vs a model.
module tb_param_vending_ctrl;

  localparam int CW    = 8;
  localparam int SW    = 4;
  localparam int PRICE = 15;
  localparam int V0    = 5;
  localparam int V1    = 10;
  localparam int SINIT = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  param_vending_ctrl_if #(.CREDIT_W(CW), .STOCK_W(SW)) bus ();

  param_vending_ctrl #(
    .CREDIT_W(CW), .PRICE(PRICE), .COIN0_VAL(V0),
    .COIN1_VAL(V1), .STOCK_W(SW), .STOCK_INIT(SINIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic cv, cs, cn, ak;
    logic e_d, e_v, e_s, e_r;
    int   e_cr, e_st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic cv, logic cs, logic cn,
                              logic ak, logic d, logic v,
                              logic s, logic r, int cr, int st);
    vec_t t;
    t.cv = cv; t.cs = cs; t.cn = cn; t.ak = ak;
    t.e_d = d; t.e_v = v; t.e_s = s; t.e_r = r;
    t.e_cr = cr; t.e_st = st;
    vecs.push_back(t);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic cv, logic cs, logic cn,
                       logic ak, logic rs, int rv);
    bus.coin_valid  = cv;
    bus.coin_sel    = cs;
    bus.cancel      = cn;
    bus.chg_ack     = ak;
    bus.restock     = rs;
    bus.restock_val = SW'(rv);
  endtask

  // reference model: credit/stock plus "vend due" and "paying out"
  int m_credit;
  int m_stock;
  bit m_vend;
  bit m_pay;

  task automatic model_check();
    bit busy;
    busy = m_vend || m_pay;
    chk("r_dispense", bus.dispense, m_vend);
    chk("r_chg_valid", bus.chg_valid, m_pay);
    chk("r_chg_sel", bus.chg_sel, m_pay && m_credit >= V1);
    chk("r_credit", bus.credit, m_credit);
    chk("r_stock", bus.stock, m_stock);
    chk("r_sold_out", bus.sold_out, m_stock == 0);
    chk("r_reject", bus.coin_reject,
        bus.coin_valid && (busy || m_stock == 0));
  endtask

  task automatic model_step();
    int  v;
    bit  acc;
    int  nstock;
    v   = bus.coin_sel ? V1 : V0;
    acc = bus.coin_valid && !m_vend && !m_pay && m_stock != 0;
    nstock = m_stock;
    if (bus.restock) nstock = int'(bus.restock_val);
    else if (m_vend && m_stock != 0) nstock = m_stock - 1;
    if (m_vend) begin
      m_vend = 0;
      m_pay  = (m_credit != 0);
    end else if (m_pay) begin
      if (bus.chg_ack) begin
        m_credit -= (m_credit >= V1) ? V1 : V0;
        if (m_credit == 0) m_pay = 0;
      end
    end else if (acc) begin
      if (m_credit + v >= PRICE) begin
        m_credit = m_credit + v - PRICE;
        m_vend   = 1;
      end else begin
        m_credit += v;
        if (bus.cancel) m_pay = 1;
      end
    end else if (bus.cancel && m_credit > 0) begin
      m_pay = 1;
    end
    m_stock = nstock;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    //            cv cs cn ak  d v s r  cr st
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    add(1, 0, 0, 0, 0, 0, 0, 0, 5, 8);
    add(1, 0, 0, 0, 0, 0, 0, 0, 10, 8);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 7);
    add(1, 1, 0, 0, 0, 0, 0, 0, 10, 7);
    add(0, 0, 0, 0, 1, 0, 0, 0, 5, 7);
    add(0, 0, 0, 0, 0, 1, 0, 0, 5, 6);
    add(0, 0, 0, 1, 0, 1, 0, 0, 5, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(0, 0, 1, 0, 0, 0, 0, 0, 5, 6);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 1, 0, 0, 5, 6);
    add(0, 0, 0, 1, 0, 1, 0, 0, 5, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 6);
    add(1, 1, 0, 0, 0, 1, 0, 1, 5, 6);
    add(0, 0, 0, 1, 0, 1, 0, 0, 5, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 6);
    add(0, 0, 1, 0, 0, 0, 0, 0, 10, 6);
    add(0, 0, 0, 0, 0, 1, 1, 0, 10, 6);
    add(0, 0, 0, 1, 0, 1, 1, 0, 10, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);

    // reset state
    @(negedge clk);
    #1;
    chk("rst_state_credit", bus.credit, 0);
    chk("rst_state_stock", bus.stock, SINIT);
    chk("rst_state_dispense", bus.dispense, 0);
    chk("rst_state_chg_valid", bus.chg_valid, 0);
    chk("rst_state_chg_sel", bus.chg_sel, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].cv, vecs[i].cs, vecs[i].cn, vecs[i].ak, 0, 0);
      #1;
      chk($sformatf("v%0d_dispense", i), bus.dispense, vecs[i].e_d);
      chk($sformatf("v%0d_chg_valid", i), bus.chg_valid, vecs[i].e_v);
      chk($sformatf("v%0d_chg_sel", i), bus.chg_sel, vecs[i].e_s);
      chk($sformatf("v%0d_reject", i), bus.coin_reject, vecs[i].e_r);
      chk($sformatf("v%0d_credit", i), bus.credit, vecs[i].e_cr);
      chk($sformatf("v%0d_stock", i), bus.stock, vecs[i].e_st);
    end

    // restock to one, buy it, then sold out rejects coins
    @(negedge clk); drive(0, 0, 0, 0, 1, 1);
    @(negedge clk); drive(1, 1, 0, 0, 0, 0);
    #1;
    chk("rs1_stock", bus.stock, 1);
    chk("rs1_sold_out", bus.sold_out, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rs1_dispense", bus.dispense, 1);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("so_sold_out", bus.sold_out, 1);
    chk("so_stock", bus.stock, 0);
    chk("so_reject", bus.coin_reject, 1);
    chk("so_credit", bus.credit, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("so_credit_after", bus.credit, 0);
    chk("so_no_dispense", bus.dispense, 0);

    // restock during the vend cycle beats the decrement
    @(negedge clk); drive(0, 0, 0, 0, 1, 3);
    @(negedge clk); drive(1, 1, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1, 9);
    #1;
    chk("rw_dispense", bus.dispense, 1);
    chk("rw_stock_pre", bus.stock, 3);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rw_stock", bus.stock, 9);

    // asynchronous reset in the middle of a refund
    @(negedge clk); drive(1, 1, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 1, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_chg_valid_pre", bus.chg_valid, 1);
    chk("ar_credit_pre", bus.credit, 10);
    #1 rst = 1'b1;
    #1;
    chk("ar_chg_valid", bus.chg_valid, 0);
    chk("ar_chg_sel", bus.chg_sel, 0);
    chk("ar_credit", bus.credit, 0);
    chk("ar_stock", bus.stock, SINIT);
    @(negedge clk);
    rst = 1'b0;

    // random traffic against the model
    m_credit = 0;
    m_stock  = SINIT;
    m_vend   = 0;
    m_pay    = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 99) < 40,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 15));
      #1;
      model_check();
      model_step();
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
